// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/handshake inputs and datapath control strobes between the sequencer and the datapath.
interface control_sequencer_if #(parameter int ALUW = 4);
    logic [31:0]     ir;
    logic            stop;
    logic            mem_ready;
    logic            pc_out;
    logic            zlow_out;
    logic            mdr_out;
    logic            mar_in;
    logic            z_in;
    logic            pc_in;
    logic            mdr_in;
    logic            ir_in;
    logic            y_in;
    logic            inc_pc;
    logic            read;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            rin;
    logic            rout;
    logic [ALUW-1:0] alu_op;
    logic            run;
    logic            illegal;
    logic [15:0]     instr_count;
    modport master (
        input  ir, stop, mem_ready,
        output pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read,
        output gra, grb, grc, rin, rout, alu_op, run, illegal, instr_count
    );
    modport slave (
        output ir, stop, mem_ready,
        input  pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read,
        input  gra, grb, grc, rin, rout, alu_op, run, illegal, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the phase-1 datapath.
// Define CONTROL_SEQUENCER_MEM_WAIT_EN to stretch T1 until mem_ready.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input logic i_clk,
    input logic i_rst,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {RST, T0, T1, T2, T3, T4, T5, HALT} state_t;
    state_t          r_state;
    state_t          w_next;
    logic            r_illegal;
    logic [15:0]     r_count;
    logic [OPW-1:0]  w_op;
    logic            w_alu;
    logic            w_nop;
    logic            w_halt;
    logic            w_done;
    logic            w_ready;
    logic            w_first;
    assign w_op   = bus.ir[31 -: OPW];
    assign w_alu  = (w_op >= OPW'(3)) && (w_op <= OPW'(8));
    assign w_nop  = w_op == OPW'(26);
    assign w_halt = w_op == OPW'(27);
    assign w_done = (r_state == T5) || (r_state == T3 && !w_alu);
`ifdef CONTROL_SEQUENCER_MEM_WAIT_EN
    logic r_t1_held;
    assign w_ready = bus.mem_ready;
    assign w_first = !r_t1_held;
    // Remembers that T1 already spent a cycle, so PCin is not pulsed twice.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_t1_held <= 1'b0;
        else       r_t1_held <= (r_state == T1) && !bus.mem_ready;
`else
    assign w_ready = 1'b1;
    assign w_first = 1'b1;
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= RST;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_done) r_count <= r_count + 16'd1;
            if (r_state == T3 && !w_alu && !w_nop && !w_halt) r_illegal <= 1'b1;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            RST:     w_next = T0;
            T0:      w_next = T1;
            T1:      w_next = w_ready ? T2 : T1;
            T2:      w_next = T3;
            T3:      w_next = w_alu ? T4 : (w_halt || bus.stop) ? HALT : T0;
            T4:      w_next = T5;
            T5:      w_next = bus.stop ? HALT : T0;
            default: w_next = HALT;
        endcase
    end
    always_comb begin
        bus.pc_out      = r_state == T0;
        bus.mar_in      = r_state == T0;
        bus.inc_pc      = r_state == T0;
        bus.z_in        = r_state == T0 || r_state == T4;
        bus.zlow_out    = (r_state == T1 && w_first) || r_state == T5;
        bus.pc_in       = r_state == T1 && w_first;
        bus.read        = r_state == T1;
        bus.mdr_in      = r_state == T1;
        bus.mdr_out     = r_state == T2;
        bus.ir_in       = r_state == T2;
        bus.grb         = r_state == T3 && w_alu;
        bus.y_in        = r_state == T3 && w_alu;
        bus.rout        = (r_state == T3 && w_alu) || r_state == T4;
        bus.grc         = r_state == T4;
        bus.alu_op      = (r_state == T4) ? ALUW'(w_op - OPW'(2)) : '0;
        bus.gra         = r_state == T5;
        bus.rin         = r_state == T5;
        bus.run         = r_state != HALT;
        bus.illegal     = r_illegal;
        bus.instr_count = r_count;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench; expected strobe sequences are built per instruction class.
module tb_control_sequencer;
    localparam logic [20:0] PCOUT = 21'h100000, ZLOW = 21'h080000, MDROUT = 21'h040000, MARIN = 21'h020000;
    localparam logic [20:0] ZIN = 21'h010000, PCIN = 21'h008000, MDRIN = 21'h004000, IRIN = 21'h002000;
    localparam logic [20:0] YIN = 21'h001000, INCPC = 21'h000800, READ = 21'h000400, GRA = 21'h000200;
    localparam logic [20:0] GRB = 21'h000100, GRC = 21'h000080, RIN = 21'h000040, ROUT = 21'h000020;
    localparam logic [20:0] RUN = 21'h000001;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_count = 16'd0;
    bit          m_illegal = 1'b0;
    bit          m_halted = 1'b0;
    logic [20:0] obs;
    always #5 clk = ~clk;
    control_sequencer_if bus ();
    control_sequencer dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    assign obs = {bus.pc_out, bus.zlow_out, bus.mdr_out, bus.mar_in, bus.z_in, bus.pc_in, bus.mdr_in,
                  bus.ir_in, bus.y_in, bus.inc_pc, bus.read, bus.gra, bus.grb, bus.grc, bus.rin,
                  bus.rout, bus.alu_op, bus.run};
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RUN || bus.instr_count !== 16'd0 || bus.illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL %s reset: strobes=%h cnt=%0d ill=%b want strobes=%h cnt=0 ill=0",
                     tag, obs, bus.instr_count, bus.illegal, RUN);
        end
        m_count = 16'd0;
        m_illegal = 1'b0;
        m_halted = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic run_instr(input logic [31:0] ir, input bit stop_end, input bit stop_noise);
        logic [20:0] exp_q[$];
        int op;
        bit alu;
        op = int'(ir[31:27]);
        alu = op >= 3 && op <= 8;
        bus.ir = ir;
        exp_q = {PCOUT | MARIN | INCPC | ZIN | RUN, ZLOW | PCIN | READ | MDRIN | RUN, MDROUT | IRIN | RUN};
        if (alu) begin
            exp_q.push_back(GRB | ROUT | YIN | RUN);
            exp_q.push_back(GRC | ROUT | ZIN | RUN | (21'(op - 2) << 1));
            exp_q.push_back(ZLOW | GRA | RIN | RUN);
        end else
            exp_q.push_back(RUN);
        foreach (exp_q[i]) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_q[i]) begin
                n_bad++;
                $display("FAIL strobes ir=%h step=%0d got=%h want=%h", ir, i, obs, exp_q[i]);
            end
            bus.stop = (i == exp_q.size() - 1) ? stop_end : (stop_noise ? 1'($urandom % 2) : 1'b0);
        end
        m_count = m_count + 16'd1;
        if (!alu && op != 26 && op != 27) m_illegal = 1'b1;
        m_halted = op == 27 || stop_end;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        n_cmp++;
        if (bus.instr_count !== m_count) begin
            n_bad++;
            $display("FAIL instr_count ir=%h got=%0d want=%0d", ir, bus.instr_count, m_count);
        end
        n_cmp++;
        if (bus.illegal !== m_illegal) begin
            n_bad++;
            $display("FAIL illegal ir=%h got=%b want=%b", ir, bus.illegal, m_illegal);
        end
        n_cmp++;
        if (bus.run !== !m_halted) begin
            n_bad++;
            $display("FAIL run ir=%h got=%b want=%b", ir, bus.run, !m_halted);
        end
        if (m_halted)
            repeat (10) begin
                @(negedge clk);
                n_cmp++;
                if (obs !== 21'd0) begin
                    n_bad++;
                    $display("FAIL halt_quiet got=%h want=0", obs);
                end
            end
    endtask
    task automatic test_reset();
        do_reset("initial");
    endtask
    task automatic test_and();
        run_instr(32'h28918000, 1'b0, 1'b0);
    endtask
    task automatic test_back_to_back();
        run_instr(32'h18918000, 1'b0, 1'b1);
        run_instr(32'h20918000, 1'b0, 1'b1);
    endtask
    task automatic test_nop_illegal();
        run_instr(32'hD0000000, 1'b0, 1'b1);
        run_instr(32'hF8000000, 1'b0, 1'b0);
        run_instr(32'h30918000, 1'b0, 1'b0);
    endtask
    task automatic test_stop();
        run_instr(32'h28918000, 1'b0, 1'b1);
        run_instr(32'h28918000, 1'b1, 1'b1);
        do_reset("after_stop");
    endtask
    task automatic test_halt();
        run_instr(32'hD8000000, 1'b0, 1'b1);
        do_reset("after_halt");
        run_instr(32'h40918000, 1'b0, 1'b0);
    endtask
    task automatic test_reset_mid();
        bus.ir = 32'h28918000;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (obs !== (GRC | ROUT | ZIN | RUN | (21'd3 << 1))) begin
            n_bad++;
            $display("FAIL mid_t4 got=%h want=%h", obs, GRC | ROUT | ZIN | RUN | (21'd3 << 1));
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.z_in !== 1'b0 || bus.alu_op !== 4'd0 || obs !== RUN) begin
            n_bad++;
            $display("FAIL async_reset zin=%b alu=%0d strobes=%h want zin=0 alu=0 strobes=%h",
                     bus.z_in, bus.alu_op, obs, RUN);
        end
        do_reset("mid_t4");
    endtask
    task automatic test_random();
        int op;
        repeat (25) begin
            case ($urandom % 4)
                0, 1:    op = int'($urandom_range(3, 8));
                2:       op = 26;
                default: op = int'($urandom_range(0, 25));
            endcase
            run_instr({5'(op), 27'($urandom)}, 1'b0, 1'b1);
        end
    endtask
    initial begin
        bus.ir = 32'd0;
        bus.stop = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_and();
        test_back_to_back();
        test_nop_illegal();
        test_stop();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the phase-1 datapath.
- Generates, cycle by cycle, the control strobes the datapath consumes: PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, plus the register-select and ALU-op encodings.
- Runs the fetch sequence T0–T2, decodes IR, and runs the execute sequence T3–T5 for three-register ALU instructions; nop and halt are also supported.
- Sits beside the Datapath: takes IR from it and drives all of its control inputs.

Parameters:
- OPW, 5, opcode width (IR[31:27])
- ALUW, 4, width of alu_op encoding

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- IR  in  32  instruction register contents from the datapath
- Stop  in  1  request to halt at the next instruction boundary
- Mem_ready  in  1  memory read complete; used only with MEM_WAIT_EN
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes
- Gra, Grb, Grc  out  1 each  select the IR Ra (IR[26:23]), Rb (IR[22:19]) or Rc (IR[18:15]) field for the register file
- Rin, Rout  out  1 each  write or drive the selected register
- alu_op  out  ALUW  ALU operation: 0 pass, 1 add, 2 sub, 3 and, 4 or, 5 shr, 6 shl
- Run  out  1  high while sequencing, low when halted
- Illegal  out  1  sticky flag: an unsupported opcode was decoded
- instr_count  out  16  count of completed instructions

Behaviour:
- State register values: RST, T0, T1, T2, T3, T4, T5, HALT.
- Outputs are Moore: decoded from the registered state plus IR, stable for the whole cycle.
- Reset (async):
  - state goes to RST; all strobes, Gra/Grb/Grc, Rin, Rout and alu_op are 0.
  - Run=1, Illegal=0, instr_count=0.
  - Asserting Reset mid-instruction drops every strobe in the same delta; no partial write completes.
- RST: all strobes 0; next state is T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Decode happens at the end of T2. From T3 on, IR holds the new instruction.
- ALU opcodes: add=3, sub=4, and=5, or=6, shr=7, shl=8.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op=op, Zin.
  - T5: Zlowout, Gra, Rin.
- nop=26: T3 goes directly to T0; the instruction counts as completed.
- halt=27: T3 goes to HALT; the instruction counts as completed.
- Any other opcode: treated as nop and sets Illegal. Illegal stays set until Reset.
- Instruction boundary (end of T5, or end of T3 for nop/illegal):
  - instr_count increments, wrapping 0xFFFF→0.
  - If Stop is high at that edge, next state is HALT; otherwise T0.
  - Stop is ignored at every other edge.
- HALT: all strobes 0, Run=0. HALT is left only by Reset.
- alu_op is 0 in every state other than T4.
- At most one of Gra/Grb/Grc is high in any cycle. Rin and Rout are never high together.
- Total latency: 6 cycles per ALU instruction, 4 per nop.

Optional Feature:
- Macro: CONTROL_SEQUENCER_MEM_WAIT_EN.
- Defined: T1 holds (Read and MDRin stay high, PCin/Zlowout only in the first T1 cycle) until Mem_ready=1; the transition to T2 happens on the edge where Mem_ready=1.
  - PCin must pulse once only, to avoid a double PC load.
- Undefined: T1 lasts exactly one cycle; the Mem_ready port exists but is ignored.

Test Plan:
- Reset, then IR=0x28918000 (and R1,R2,R3) presented from T2 onward:
  - T0–T5 occur on 6 consecutive cycles with the exact strobe sets above.
  - T4 has alu_op=3 with Grc.
  - T5 has Gra, Rin.
  - instr_count=1 afterwards.
- IR=0x18918000 (add), then IR=0x20918000 (sub) back-to-back:
  - alu_op=1, then 2, in the respective T4 cycles.
  - instr_count=2 after 12 cycles.
- IR=0xD8000000 (halt):
  - reaches HALT after T3; Run=0 and all strobes 0 for 10 further cycles.
  - Reset returns to RST, then T0 with Run=1.
- IR=0xF8000000 (opcode 31):
  - Illegal=1 after T3; next state T0; Illegal still 1 after the next valid instruction.
- Stop pulsed high during T3 of an and instruction only: no halt. Stop held high through the end of T5: HALT on the next cycle.
- Reset asserted asynchronously mid-T4: Zin and alu_op fall to 0 immediately, before the next edge. With the macro defined, Mem_ready low for 3 cycles holds T1 for 4 cycles with PCin high only in the first.
